// File: rtl/multi_downcounter_pkg.sv
// Shared definitions for the multi-channel down-counter bank:
// the default reload period and the channel-select width helper.
package multi_downcounter_pkg;

  localparam int unsigned DEFAULT_RESET_PERIOD = 15;

  // A one-channel bank still gets a 1-bit select so the ports never collapse to zero width.
  function automatic int sel_width(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/dc_channel.sv
// One down-counter channel: period/count registers, enable edge detect,
// command priority (restart > load_count > load > tick), zero pulse and sticky expired.
module dc_channel
  import multi_downcounter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_RESET_PERIOD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             restart,
  input  logic             load,
  input  logic             load_count,
  input  logic [WIDTH-1:0] wr_value,
  input  logic             clear_expired,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic [1:0]       hist_reg;
  logic             zprev_reg;
  logic             expired_reg;
  logic             tick;
  logic             count_is_zero;

  assign tick          = (hist_reg == 2'b01);
  assign count_is_zero = (count_reg == '0);
  assign zero          = count_is_zero & ~zprev_reg;
  assign count         = count_reg;
  assign expired       = expired_reg;

  always_comb begin
    count_next  = count_reg;
    period_next = period_reg;
    if (restart) begin
      count_next = period_reg;
    end else if (load_count) begin
      count_next = wr_value;
    end else if (load) begin
      // A zero period would make auto-reload degenerate, so it falls back to the reset period.
      if (wr_value != '0) begin
        count_next  = wr_value;
        period_next = wr_value;
      end else begin
        count_next  = RESET_PERIOD;
        period_next = RESET_PERIOD;
      end
    end else if (tick) begin
      if (!count_is_zero) begin
        count_next = count_reg - 1'b1;
      end else if (auto_reload) begin
        count_next = period_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg   <= RESET_PERIOD;
      period_reg  <= RESET_PERIOD;
      hist_reg    <= 2'b00;
      zprev_reg   <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      period_reg <= period_next;
      hist_reg   <= {hist_reg[0], enable};
      zprev_reg  <= count_is_zero;
      if (zero) begin
        expired_reg <= 1'b1;
      end else if (clear_expired) begin
        expired_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_downcounter.sv
// Bank of independent down-counters: decodes the write select onto the channels,
// registers the selected count for readback and ORs the zero pulses.
module multi_downcounter
  import multi_downcounter_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int          CHANNELS     = 4,
  parameter int unsigned RESET_PERIOD = DEFAULT_RESET_PERIOD
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNELS-1:0]                enable,
  input  logic [CHANNELS-1:0]                auto_reload,
  input  logic [CHANNELS-1:0]                restart,
  input  logic [sel_width(CHANNELS)-1:0]     sel,
  input  logic                               load,
  input  logic                               load_count,
  input  logic [WIDTH-1:0]                   wr_value,
  input  logic [CHANNELS-1:0]                clear_expired,
  input  logic [sel_width(CHANNELS)-1:0]     rd_sel,
  output logic [WIDTH-1:0]                   rd_value,
  output logic [CHANNELS-1:0]                zero,
  output logic [CHANNELS-1:0]                expired,
  output logic                               any_zero
);

  localparam int SW = sel_width(CHANNELS);

  logic [WIDTH-1:0] counts [CHANNELS];
  logic [WIDTH-1:0] rd_next;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
    // An out-of-range sel matches no channel, so such writes fall on the floor.
    logic sel_hit;
    assign sel_hit = (sel == SW'(gi));

    dc_channel #(
      .WIDTH        (WIDTH),
      .RESET_PERIOD (WIDTH'(RESET_PERIOD))
    ) u_channel (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable[gi]),
      .auto_reload   (auto_reload[gi]),
      .restart       (restart[gi]),
      .load          (load & sel_hit),
      .load_count    (load_count & sel_hit),
      .wr_value      (wr_value),
      .clear_expired (clear_expired[gi]),
      .count         (counts[gi]),
      .zero          (zero[gi]),
      .expired       (expired[gi])
    );
  end

  assign any_zero = |zero;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SW'(i)) begin
        rd_next = counts[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_value <= '0;
    end else begin
      rd_value <= rd_next;
    end
  end

endmodule

// File: tb/tb_multi_downcounter.sv
// Directed self-checking bench for multi_downcounter with hand-computed expectations.
module tb_multi_downcounter;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [CHANNELS-1:0] enable = '0;
  logic [CHANNELS-1:0] auto_reload = '0;
  logic [CHANNELS-1:0] restart = '0;
  logic [1:0]          sel = '0;
  logic                load = 1'b0;
  logic                load_count = 1'b0;
  logic [WIDTH-1:0]    wr_value = '0;
  logic [CHANNELS-1:0] clear_expired = '0;
  logic [1:0]          rd_sel = '0;
  logic [WIDTH-1:0]    rd_value;
  logic [CHANNELS-1:0] zero;
  logic [CHANNELS-1:0] expired;
  logic                any_zero;

  int checks = 0;
  int failures = 0;
  int zero_cnt [CHANNELS];
  int any_cnt = 0;

  multi_downcounter #(
    .WIDTH        (WIDTH),
    .CHANNELS     (CHANNELS),
    .RESET_PERIOD (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .auto_reload   (auto_reload),
    .restart       (restart),
    .sel           (sel),
    .load          (load),
    .load_count    (load_count),
    .wr_value      (wr_value),
    .clear_expired (clear_expired),
    .rd_sel        (rd_sel),
    .rd_value      (rd_value),
    .zero          (zero),
    .expired       (expired),
    .any_zero      (any_zero)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < CHANNELS; i++) zero_cnt[i] = 0;
  end

  // Each zero pulse lasts exactly one cycle, so a negedge sample sees it once.
  always @(negedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (zero[i]) zero_cnt[i] <= zero_cnt[i] + 1;
    end
    if (any_zero) any_cnt <= any_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One enable pulse; on return rd_value already shows the post-tick count.
  task automatic pulse(input int ch);
    enable[ch] = 1'b1;
    step();
    enable[ch] = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++;
    if (rd_value !== 32'd15) begin
      failures++;
      $display("FAIL reset_count0 actual=%0d required=15", rd_value);
    end
    checks++;
    if (zero !== 4'b0000 || expired !== 4'b0000 || any_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags actual zero=%b expired=%b any=%b required 0", zero, expired, any_zero);
    end
    $display("test_reset: count0=%0d zero=%b expired=%b", rd_value, zero, expired);
  endtask

  task automatic test_one_shot();
    int base;
    base = zero_cnt[0];
    rd_sel = 2'd0;
    for (int k = 1; k <= 15; k++) begin
      pulse(0);
      checks++;
      if (rd_value !== WIDTH'(15 - k)) begin
        failures++;
        $display("FAIL one_shot_count pulse=%0d actual=%0d required=%0d", k, rd_value, 15 - k);
      end
    end
    checks++;
    if (zero_cnt[0] - base !== 1) begin
      failures++;
      $display("FAIL one_shot_pulses actual=%0d required=1", zero_cnt[0] - base);
    end
    checks++;
    if (expired[0] !== 1'b1) begin
      failures++;
      $display("FAIL one_shot_expired actual=%b required=1", expired[0]);
    end
    pulse(0);
    checks++;
    if (rd_value !== 32'd0 || zero_cnt[0] - base !== 1) begin
      failures++;
      $display("FAIL one_shot_hold actual count=%0d pulses=%0d required 0 and 1", rd_value, zero_cnt[0] - base);
    end
    $display("test_one_shot: count=%0d pulses=%0d expired=%b", rd_value, zero_cnt[0] - base, expired[0]);
  endtask

  task automatic test_auto_reload();
    int base;
    int exp_seq [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    auto_reload[2] = 1'b1;
    sel = 2'd2;
    wr_value = 32'd3;
    load = 1'b1;
    step();
    load = 1'b0;
    rd_sel = 2'd2;
    base = zero_cnt[2];
    for (int k = 0; k < 8; k++) begin
      pulse(2);
      checks++;
      if (rd_value !== WIDTH'(exp_seq[k])) begin
        failures++;
        $display("FAIL auto_reload_count pulse=%0d actual=%0d required=%0d", k + 1, rd_value, exp_seq[k]);
      end
    end
    checks++;
    if (zero_cnt[2] - base !== 2) begin
      failures++;
      $display("FAIL auto_reload_pulses actual=%0d required=2", zero_cnt[2] - base);
    end
    $display("test_auto_reload: final=%0d pulses=%0d", rd_value, zero_cnt[2] - base);
  endtask

  task automatic test_zero_load();
    int base_any;
    rd_sel = 2'd1;
    sel = 2'd1;
    wr_value = 32'd5;
    load = 1'b1;
    step();
    wr_value = 32'd0;
    step();
    load = 1'b0;
    step();
    checks++;
    if (rd_value !== 32'd15) begin
      failures++;
      $display("FAIL zero_load_count actual=%0d required=15", rd_value);
    end
    wr_value = 32'd4;
    load_count = 1'b1;
    step();
    load_count = 1'b0;
    restart[1] = 1'b1;
    step();
    restart[1] = 1'b0;
    step();
    checks++;
    if (rd_value !== 32'd15) begin
      failures++;
      $display("FAIL zero_load_period actual=%0d required=15", rd_value);
    end
    base_any = any_cnt;
    wr_value = 32'd0;
    load_count = 1'b1;
    step();
    load_count = 1'b0;
    checks++;
    if (zero[1] !== 1'b1 || any_zero !== 1'b1) begin
      failures++;
      $display("FAIL load_count_zero_pulse actual zero1=%b any=%b required 1", zero[1], any_zero);
    end
    step();
    checks++;
    if (zero[1] !== 1'b0 || expired[1] !== 1'b1 || any_cnt - base_any !== 1) begin
      failures++;
      $display("FAIL load_count_zero_after actual zero1=%b expired1=%b anypulses=%0d required 0,1,1",
               zero[1], expired[1], any_cnt - base_any);
    end
    $display("test_zero_load: expired1=%b", expired[1]);
  endtask

  task automatic test_priority();
    rd_sel = 2'd3;
    pulse(3);
    checks++;
    if (rd_value !== 32'd14) begin
      failures++;
      $display("FAIL priority_pre actual=%0d required=14", rd_value);
    end
    enable[3] = 1'b1;
    step();
    enable[3] = 1'b0;
    restart[3] = 1'b1;
    load_count = 1'b1;
    sel = 2'd3;
    wr_value = 32'd7;
    step();
    restart[3] = 1'b0;
    load_count = 1'b0;
    step();
    step();
    checks++;
    if (rd_value !== 32'd15) begin
      failures++;
      $display("FAIL priority_restart actual=%0d required=15", rd_value);
    end
    $display("test_priority: count3=%0d", rd_value);
  endtask

  task automatic test_clear_expired();
    clear_expired[0] = 1'b1;
    step();
    clear_expired[0] = 1'b0;
    checks++;
    if (expired[0] !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_zero actual=%b required=0", expired[0]);
    end
    sel = 2'd0;
    wr_value = 32'd1;
    load_count = 1'b1;
    step();
    wr_value = 32'd0;
    step();
    load_count = 1'b0;
    checks++;
    if (zero[0] !== 1'b1) begin
      failures++;
      $display("FAIL clear_zero_pulse actual=%b required=1", zero[0]);
    end
    clear_expired[0] = 1'b1;
    step();
    clear_expired[0] = 1'b0;
    checks++;
    if (expired[0] !== 1'b1) begin
      failures++;
      $display("FAIL clear_set_wins actual=%b required=1", expired[0]);
    end
    clear_expired[0] = 1'b1;
    step();
    clear_expired[0] = 1'b0;
    checks++;
    if (expired[0] !== 1'b0) begin
      failures++;
      $display("FAIL clear_later actual=%b required=0", expired[0]);
    end
    $display("test_clear_expired: expired0=%b", expired[0]);
  endtask

  task automatic test_reset_mid_count();
    rd_sel = 2'd3;
    enable[0] = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (rd_value !== 32'd0 || zero !== 4'b0000 || expired !== 4'b0000 || any_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs actual rd=%0d zero=%b expired=%b any=%b required all 0",
               rd_value, zero, expired, any_zero);
    end
    step();
    reset = 1'b1;
    rd_sel = 2'd0;
    repeat (5) step();
    checks++;
    if (rd_value !== 32'd14) begin
      failures++;
      $display("FAIL reset_one_tick actual=%0d required=14", rd_value);
    end
    enable[0] = 1'b0;
    $display("test_reset_mid_count: count0=%0d", rd_value);
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_zero_load();
    test_priority();
    test_clear_expired();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_downcounter.md
# multi_downcounter

Parametrised bank of independent down-counters: CHANNELS channels, each WIDTH bits wide, each with its own period register, tick input, one-shot or auto-reload mode, zero pulse and sticky expired flag. It is the next generation of the single-channel sniffer downcounter. It sits between the bus-match logic, which drives per-channel ticks, and the register file, which loads periods and counts and reads back current values.

## Interface
- WIDTH, 32, counter and period width.
- CHANNELS, 4, number of channels, 1..16.
- RESET_PERIOD, 15, period and count after reset or after a zero-period load; range 1..2^WIDTH-1.
- SW = max(1, clog2(CHANNELS)), derived, select width.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- enable  in  CHANNELS  per-channel tick request; rising-edge detected.
- auto_reload  in  CHANNELS  1 = reload period on tick at zero; 0 = one-shot, hold at 0.
- restart  in  CHANNELS  per-channel: count <= period.
- sel  in  SW  channel targeted by load/load_count.
- load  in  1  write wr_value to the period and count of channel sel.
- load_count  in  1  write wr_value to the count only of channel sel.
- wr_value  in  WIDTH  write data.
- clear_expired  in  CHANNELS  clears the sticky expired bits.
- rd_sel  in  SW  readback channel.
- rd_value  out  WIDTH  registered count of channel rd_sel.
- zero  out  CHANNELS  one-cycle pulse when a count enters 0.
- expired  out  CHANNELS  sticky; set by zero, cleared by clear_expired.
- any_zero  out  1  OR of zero.

## Operation
- Tick detection: per channel, hist <= {hist[0], enable[i]}; tick = (hist == 2'b01).
- Priority per channel per cycle:
  1. restart[i]
  2. load_count with sel == i
  3. load with sel == i
  4. tick
  5. hold
- load: if wr_value != 0, period and count <= wr_value; otherwise period and count <= RESET_PERIOD.
- load_count: count <= wr_value. Zero is accepted and produces a zero pulse.
- Tick with count != 0: count <= count - 1.
- Tick with count == 0:
  - auto_reload[i] = 1: count <= period.
  - auto_reload[i] = 0: count stays 0. No further zero pulse until the count leaves 0 and returns.
- No wrap-around: a count of 0 never decrements to all-ones.
- zero[i] = (count == 0) & ~zprev[i], where zprev <= (count == 0).
- expired[i]: set on zero[i]. Set wins over clear_expired[i] in the same cycle.
- sel or rd_sel >= CHANNELS: writes are ignored; rd_value <= 0.
- Reset values:
  - count = period = RESET_PERIOD
  - hist = 0, zprev = 0
  - zero = 0, expired = 0, any_zero = 0, rd_value = 0
- Reset asserted mid-count returns all state to the reset values immediately.
- enable held high across reset release yields exactly one tick.

## Timing
- enable first sampled high at edge E: tick is true between E and E+1; count decrements at E+1.
- Count reaches 0 at edge N: zero and any_zero are high from N to N+1; expired is set at N+1.
- load, load_count and restart take effect at the sampling edge. No handshake; the command is single-cycle.
- rd_value: 1-cycle latency from rd_sel.
- Auto-reload period P: zero pulses every P+1 ticks.

## Structure
- Shared package holds:
  - the RESET_PERIOD default
  - the SW select-width function
- Sub-module dc_channel: one channel, holding count, period, hist, zprev, expired and the priority logic. Instantiate it CHANNELS times in a generate loop.
- The top level holds the sel decode, the rd_value mux register and the any_zero OR.

## Test plan
- Reset, then 15 enable pulses on channel 0 (one-shot) -> count 15→0, a single zero[0] pulse, expired[0] = 1; a 16th pulse leaves count at 0 with no pulse.
- load sel = 2, wr_value = 3, auto_reload[2] = 1, 8 pulses -> counts 2,1,0,3,2,1,0,3; zero[2] pulses twice.
- load with wr_value = 0 on channel 1 -> period and count = 15; load_count 0 on channel 1 -> zero[1] pulse next cycle.
- restart[3] and load_count sel = 3 in the same cycle as a tick -> count = period; load_count and the tick are ignored.
- clear_expired[0] asserted in the same cycle as zero[0] -> expired[0] remains 1; a later clear with no zero -> expired[0] = 0.
- Reset asserted mid-count with enable held high -> all outputs at reset values; after release, exactly one decrement to 14.
